// File: rtl/sha512_pkg.sv
// Shared types and constants for the SHA-512 padding front end.
package sha512_pkg;

  typedef logic [63:0] word_t;
  typedef word_t [0:15] block_t;

  typedef enum logic [1:0] {
    FILL = 2'd0,
    PAD  = 2'd1,
    OUT  = 2'd2
  } state_e;

  localparam word_t PAD_MARKER = 64'h8000_0000_0000_0000;
  localparam int    LEN_HI_IDX = 14;
  localparam int    LEN_LO_IDX = 15;

  // Upper word of the 128-bit bit-length field for a byte count l.
  function automatic word_t len_hi(input logic [63:0] l);
    return {61'b0, l[63:61]};
  endfunction

  // Lower word of the 128-bit bit-length field for a byte count l.
  function automatic word_t len_lo(input logic [63:0] l);
    return {l[60:0], 3'b000};
  endfunction

endpackage

// File: rtl/sha512_padder_if.sv
// Message-in / block-out bundle of the SHA-512 padder.
//
// Both streams use strict valid/ready: a transfer happens on a rising clock
// edge where valid and ready are both high. Once valid is raised, the
// producer holds valid and its payload stable until that transfer; ready may
// be driven combinationally and never depends on valid.
interface sha512_padder_if;
  import sha512_pkg::*;

  logic        in_valid;
  logic        in_ready;
  word_t       in_data;
  logic        in_last;
  logic [3:0]  in_bytes;

  logic        out_valid;
  logic        out_ready;
  block_t      out_w;
  logic        out_last;

  // Message source / block sink side.
  modport master (
    output in_valid, in_data, in_last, in_bytes, out_ready,
    input  in_ready, out_valid, out_w, out_last
  );

  // Padder side.
  modport slave (
    input  in_valid, in_data, in_last, in_bytes, out_ready,
    output in_ready, out_valid, out_w, out_last
  );

endinterface

// File: rtl/sha512_pad_word.sv
// Final-word masker: keeps bytes below n, puts 0x80 at byte n (n<8),
// zeroes everything after. Byte 0 is the most significant byte.
module sha512_pad_word
  import sha512_pkg::*;
(
  input  word_t      i_word,
  input  logic [3:0] i_n,
  output word_t      o_word
);

  // Byte-wise select between data, marker and zero.
  always_comb begin
    o_word = '0;
    for (int b = 0; b < 8; b++) begin
      if (4'(b) < i_n) begin
        o_word[63-8*b -: 8] = i_word[63-8*b -: 8];
      end else if (4'(b) == i_n) begin
        o_word[63-8*b -: 8] = 8'h80;
      end
    end
  end

endmodule

// File: rtl/sha512_padder.sv
// SHA-512 message padder: collects 64-bit words into 16-word blocks, adds the
// 0x80 marker, zero fill and 128-bit bit length, and emits one or two final
// blocks per message.
module sha512_padder
  import sha512_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  sha512_padder_if.slave  io_bus,
  output state_e          o_dbg_state
);

  state_e      r_state;
  state_e      w_next;
  block_t      r_buf;
  logic [3:0]  r_idx;
  logic [63:0] r_len;
  logic        r_marker_done;
  logic        r_extra_pending;
  logic        r_out_last;

  logic        w_in_hs;
  logic        w_out_hs;
  word_t       w_pad_word;
  logic [3:0]  w_mark_idx;
  logic        w_has_marker;
  logic        w_len_fits;

  sha512_pad_word u_pad_word (
    .i_word (io_bus.in_data),
    .i_n    (io_bus.in_bytes),
    .o_word (w_pad_word)
  );

  assign w_in_hs  = io_bus.in_valid  && (r_state == FILL);
  assign w_out_hs = io_bus.out_ready && (r_state == OUT);

  // Where the marker ends up after PAD. With a full last word in slot 15
  // there is no room for it, so it moves to the extra block.
  assign w_mark_idx   = r_marker_done ? r_idx : r_idx + 4'd1;
  assign w_has_marker = r_marker_done || (r_idx != 4'd15);
  assign w_len_fits   = w_has_marker && (w_mark_idx <= 4'd13);

  assign io_bus.in_ready  = (r_state == FILL);
  assign io_bus.out_valid = (r_state == OUT);
  assign io_bus.out_w     = r_buf;
  assign io_bus.out_last  = r_out_last;
  assign o_dbg_state      = r_state;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= FILL;
    else        r_state <= w_next;
  end

  // Next-state decode.
  always_comb begin
    w_next = r_state;
    case (r_state)
      FILL: begin
        if (w_in_hs) begin
          if (io_bus.in_last)      w_next = PAD;
          else if (r_idx == 4'd15) w_next = OUT;
        end
      end
      PAD:     w_next = OUT;
      OUT:     if (w_out_hs && !r_extra_pending) w_next = FILL;
      default: w_next = FILL;
    endcase
  end

  // Block buffer, word index, byte count and padding flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_buf           <= '0;
      r_idx           <= '0;
      r_len           <= '0;
      r_marker_done   <= 1'b0;
      r_extra_pending <= 1'b0;
      r_out_last      <= 1'b0;
    end else begin
      case (r_state)
        FILL: begin
          if (w_in_hs) begin
            if (!io_bus.in_last) begin
              r_buf[r_idx] <= io_bus.in_data;
              r_len        <= r_len + 64'd8;
              if (r_idx == 4'd15) begin
                r_idx      <= '0;
                r_out_last <= 1'b0;
              end else begin
                r_idx <= r_idx + 4'd1;
              end
            end else begin
              r_buf[r_idx] <= w_pad_word;
              r_len        <= r_len + {60'b0, io_bus.in_bytes};
              if (io_bus.in_bytes < 4'd8) r_marker_done <= 1'b1;
            end
          end
        end
        PAD: begin
          // Later assignments in this branch override the zero fill.
          for (int k = 0; k < 16; k++) begin
            if (k > int'(r_idx)) r_buf[k] <= '0;
          end
          if (!r_marker_done && (r_idx != 4'd15)) begin
            r_buf[r_idx + 4'd1] <= PAD_MARKER;
            r_marker_done       <= 1'b1;
          end
          if (w_len_fits) begin
            r_buf[LEN_HI_IDX] <= len_hi(r_len);
            r_buf[LEN_LO_IDX] <= len_lo(r_len);
            r_out_last        <= 1'b1;
          end else begin
            r_out_last      <= 1'b0;
            r_extra_pending <= 1'b1;
          end
        end
        OUT: begin
          if (w_out_hs) begin
            if (r_extra_pending) begin
              for (int k = 0; k < 16; k++) r_buf[k] <= '0;
              r_buf[0]          <= r_marker_done ? '0 : PAD_MARKER;
              r_buf[LEN_HI_IDX] <= len_hi(r_len);
              r_buf[LEN_LO_IDX] <= len_lo(r_len);
              r_marker_done     <= 1'b1;
              r_out_last        <= 1'b1;
              r_extra_pending   <= 1'b0;
            end else if (r_out_last) begin
              r_len         <= '0;
              r_idx         <= '0;
              r_marker_done <= 1'b0;
              r_out_last    <= 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
